uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_tx_engine.sv | 135 +++++++++++++
 tb/tb_uart_tx_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops bytes from a FIFO and serialises them.
// Frame is start, 8 data bits LSB first, optional parity, 1-2 stop bits.
module uart_tx_engine #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENABLE,
    input  logic       BUFFER_AVAIL,
    input  logic [7:0] BUFFER_DATA,
    output logic       READ_BUFFER,
    output logic       TX,
    output logic       BUSY,
    output logic       DONE
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_PARITY = 3'd5;
    localparam logic [2:0] S_STOP   = 3'd6;

    logic [2:0]    state;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          par_bit;
    logic          bit_end;

    assign bit_end = (baud == LAST_CNT);
    assign BUSY    = (state != S_IDLE);

    // TX is loaded together with the state change so it never lags the FSM.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            baud        <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            par_bit     <= 1'b0;
            TX          <= 1'b1;
            READ_BUFFER <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            READ_BUFFER <= 1'b0;
            DONE        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ENABLE && BUFFER_AVAIL) begin
                        state       <= S_FETCH;
                        READ_BUFFER <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    shift   <= BUFFER_DATA;
                    par_bit <= (PARITY == 2) ? ~^BUFFER_DATA : ^BUFFER_DATA;
                    baud    <= '0;
                    TX      <= 1'b0;
                    state   <= S_START;
                end
                S_START: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        TX      <= shift[0];
                        state   <= S_DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud  <= '0;
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            if (PARITY != 0) begin
                                TX    <= par_bit;
                                state <= S_PARITY;
                            end else begin
                                TX    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            TX      <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        TX      <= 1'b1;
                        state   <= S_STOP;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            DONE    <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    TX    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: four lanes (no/even/odd parity, two stop bits)
// fed from FIFO models and checked cycle by cycle against a frame model.
module tb_uart_tx_engine;

    localparam int CPB = 4;
    localparam int N   = 4;

    typedef logic [7:0] bq_t[$];

    logic       CLK;
    logic       rst;
    logic       en;
    logic       avail [N];
    logic [7:0] bdata [N];
    logic       rb    [N];
    logic       tx    [N];
    logic       busy  [N];
    logic       done  [N];

    bq_t        fifo  [N];
    bq_t        sbq   [N];
    int         mt    [N];
    logic       mdone [N];
    logic [7:0] cur   [N];

    int   errors;
    int   checks;
    logic tmo;
    logic tmo_seen;

    function automatic int par_of(input int g);
        return (g == 1) ? 1 : (g == 2) ? 2 : 0;
    endfunction

    function automatic int stop_of(input int g);
        return (g == 3) ? 2 : 1;
    endfunction

    // Busy span: FETCH + LOAD + every serial bit of the frame.
    function automatic int frame_len(input int g);
        return 2 + CPB * (9 + ((par_of(g) != 0) ? 1 : 0) + stop_of(g));
    endfunction

    // Line level of serial bit 'idx' of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int p,
                                     input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (p != 0 && idx == 9) return (p == 1) ? ^b : ~^b;
        return 1'b1;
    endfunction

    for (genvar g = 0; g < N; g++) begin : lane
        localparam int P = (g == 1) ? 1 : (g == 2) ? 2 : 0;
        localparam int S = (g == 3) ? 2 : 1;
        uart_tx_engine #(
            .CLKS_PER_BIT(CPB),
            .PARITY      (P),
            .STOP_BITS   (S)
        ) dut (
            .CLK         (CLK),
            .RST         (rst),
            .ENABLE      (en),
            .BUFFER_AVAIL(avail[g]),
            .BUFFER_DATA (bdata[g]),
            .READ_BUFFER (rb[g]),
            .TX          (tx[g]),
            .BUSY        (busy[g]),
            .DONE        (done[g])
        );
    end

    initial begin
        CLK = 1'b1;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input int g,
                         input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane=%0d time=%0t actual=%b required=%b",
                     name, g, $time, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        tmo_seen = 1'b0;
        for (int g = 0; g < N; g++) begin
            mt[g]    = -1;
            mdone[g] = 1'b0;
            cur[g]   = 8'h00;
        end
        forever begin
            @(negedge CLK or posedge rst);
            if (CLK === 1'b1) begin
                #1;
                for (int g = 0; g < N; g++) begin
                    check("async_rst_tx", g, tx[g], 1'b1);
                    check("async_rst_busy", g, busy[g], 1'b0);
                    check("async_rst_rd", g, rb[g], 1'b0);
                    check("async_rst_done", g, done[g], 1'b0);
                end
            end else if (rst) begin
                for (int g = 0; g < N; g++) begin
                    check("rst_tx", g, tx[g], 1'b1);
                    check("rst_busy", g, busy[g], 1'b0);
                    check("rst_rd", g, rb[g], 1'b0);
                    check("rst_done", g, done[g], 1'b0);
                    mt[g]    = -1;
                    mdone[g] = 1'b0;
                    sbq[g].delete();
                end
            end else begin
                if (tmo && !tmo_seen) begin
                    tmo_seen = 1'b1;
                    checks++;
                    errors++;
                    $display("FAIL idle_timeout time=%0t actual=busy required=idle",
                             $time);
                end
                for (int g = 0; g < N; g++) begin
                    if (mt[g] == 2) begin
                        checks++;
                        if (sbq[g].size() == 0) begin
                            errors++;
                            $display("FAIL frame_without_pop lane=%0d time=%0t actual=start required=none",
                                     g, $time);
                            cur[g] = 8'h00;
                        end else begin
                            cur[g] = sbq[g].pop_front();
                        end
                    end
                    check("read_buffer", g, rb[g], mt[g] == 0);
                    check("busy", g, busy[g], mt[g] >= 0);
                    check("done", g, done[g], mdone[g]);
                    check("tx", g, tx[g],
                          (mt[g] >= 2) ? exp_bit(cur[g], par_of(g), (mt[g] - 2) / CPB)
                                       : 1'b1);
                    if (rb[g] && fifo[g].size() != 0) begin
                        bdata[g] = fifo[g].pop_front();
                        sbq[g].push_back(bdata[g]);
                        avail[g] = (fifo[g].size() != 0);
                    end
                    mdone[g] = 1'b0;
                    if (mt[g] >= 0) begin
                        mt[g]++;
                        if (mt[g] == frame_len(g)) begin
                            mt[g]    = -1;
                            mdone[g] = 1'b1;
                        end
                    end else if (en && avail[g]) begin
                        mt[g] = 0;
                    end
                end
            end
        end
    end

    task automatic push(input int g, input logic [7:0] b);
        fifo[g].push_back(b);
        avail[g] = 1'b1;
    endtask

    task automatic push_all_random();
        for (int g = 0; g < N; g++) push(g, 8'($urandom));
    endtask

    function automatic logic all_idle();
        for (int g = 0; g < N; g++)
            if (mt[g] != -1 || fifo[g].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge CLK);
            #2;
            n++;
        end while (!all_idle() && n < 4000);
        if (n >= 4000) tmo = 1'b1;
    endtask

    // Stimulus
    initial begin
        errors = 0;
        checks = 0;
        tmo    = 1'b0;
        rst    = 1'b0;
        en     = 1'b0;
        for (int g = 0; g < N; g++) begin
            avail[g] = 1'b0;
            bdata[g] = 8'h00;
        end
        #1 rst = 1'b1;
        repeat (3) @(posedge CLK);
        #2 rst = 1'b0;

        push(0, 8'hA5);
        push(1, 8'h07);
        push(2, 8'h07);
        push(3, 8'h55);
        en = 1'b1;
        wait_idle();

        push(0, 8'h00);
        push(0, 8'hFF);
        for (int g = 1; g < N; g++) begin
            push(g, 8'($urandom));
            push(g, 8'($urandom));
        end
        wait_idle();

        en = 1'b0;
        push_all_random();
        repeat (30) @(posedge CLK);
        #2 en = 1'b1;
        wait_idle();

        push_all_random();
        push_all_random();
        repeat (3) @(posedge CLK);
        #2 en = 1'b0;
        repeat (70) @(posedge CLK);
        #2 en = 1'b1;
        wait_idle();

        push_all_random();
        repeat (20) @(posedge CLK);
        #2 rst = 1'b1;
        repeat (2) @(posedge CLK);
        #2 rst = 1'b0;
        push_all_random();
        wait_idle();

        for (int it = 0; it < 12; it++) begin
            for (int g = 0; g < N; g++) begin
                int k;
                k = $urandom_range(0, 3);
                for (int j = 0; j < k; j++) push(g, 8'($urandom));
            end
            en = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 60)) @(posedge CLK);
            #2;
        end
        en = 1'b1;
        wait_idle();

        repeat (4) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
